// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative HI/LO multiply/divide unit for a MIPS-style pipeline.
// Multiply uses radix-2 shift-add and divide uses radix-2 restoring division.
// Each iterates one bit per clock over magnitudes, and the sign is corrected in a final FIX state.
// Optional macro MULDIV_FAST_MUL_EN turns MULT/MULTU into a single-cycle multiply.
// In that build HI/LO are written at the accept edge and the FSM stays IDLE.
module muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic                  i_Start,
    input  logic [1:0]            i_Op,
    input  logic [DATA_WIDTH-1:0] i_SrcA,
    input  logic [DATA_WIDTH-1:0] i_SrcB,
    input  logic                  i_Kill,
    input  logic                  i_MTHI,
    input  logic                  i_MTLO,
    output logic                  o_Busy,
    output logic                  o_Done,
    output logic                  o_DivByZero,
    output logic [DATA_WIDTH-1:0] o_HI,
    output logic [DATA_WIDTH-1:0] o_LO
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX} stateT;

    stateT           state, nextState;
    logic [CW-1:0]   counter;
    logic [W-1:0]    accHi, accLo, opB;
    logic [W-1:0]    hiReg, loReg;
    logic            isDiv, negRes, negRem, divZero;
    logic            doneReg, dbzReg;

    logic            isMulOp, isSignedOp, signA, signB;
    logic [W-1:0]    magA, magB;
    logic            acceptStart, fastMul;
    logic [W:0]      mulSum, divShift, divDiff;
    logic            divFits;
    logic [2*W-1:0]  product, prodFixed;
    logic [W-1:0]    resHi, resLo;
`ifdef MULDIV_FAST_MUL_EN
    logic [2*W-1:0]  fastProd;
`endif

    // Decode the request and form operand magnitudes and signs for the accept edge
    always_comb begin
        isMulOp     = ~i_Op[1];
        isSignedOp  = ~i_Op[0];
        signA       = isSignedOp & i_SrcA[W-1];
        signB       = isSignedOp & i_SrcB[W-1];
        magA        = signA ? -i_SrcA : i_SrcA;
        magB        = signB ? -i_SrcB : i_SrcB;
        acceptStart = (state == IDLE) & i_Start & ~i_Kill;
`ifdef MULDIV_FAST_MUL_EN
        fastMul     = acceptStart & isMulOp;
        fastProd    = {{W{signA}}, i_SrcA} * {{W{signB}}, i_SrcB};
`else
        fastMul     = 1'b0;
`endif
    end

    // One radix-2 step for both multiply (shift-add) and restoring divide
    always_comb begin
        mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, opB} : '0);
        divShift = {accHi, accLo[W-1]};
        divFits  = (divShift >= {1'b0, opB});
        divDiff  = divShift - {1'b0, opB};
    end

    // Sign correction of the finished magnitude result; a zero divisor forces LO to all ones
    // while the remainder path naturally reproduces the original dividend in HI
    always_comb begin
        product   = {accHi, accLo};
        prodFixed = negRes ? -product : product;
        if (isDiv) begin
            resLo = divZero ? '1 : (negRes ? -accLo : accLo);
            resHi = negRem ? -accHi : accHi;
        end else begin
            resHi = prodFixed[2*W-1:W];
            resLo = prodFixed[W-1:0];
        end
    end

    // FSM state register
    always_ff @(posedge i_CLK) begin
        if (i_RST) state <= IDLE;
        else       state <= nextState;
    end

    // FSM next-state logic; kill aborts from any busy state
    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (acceptStart && !fastMul) nextState = RUN;
            RUN:  if (i_Kill)                  nextState = IDLE;
                  else if (counter == '0)      nextState = FIX;
            FIX:                               nextState = IDLE;
            default:                           nextState = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        o_Busy      = (state != IDLE);
        o_Done      = doneReg;
        o_DivByZero = dbzReg;
        o_HI        = hiReg;
        o_LO        = loReg;
    end

    // Datapath: operand latch, iteration, result write-back and HI/LO moves
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            counter <= '0;
            accHi   <= '0;
            accLo   <= '0;
            opB     <= '0;
            hiReg   <= '0;
            loReg   <= '0;
            isDiv   <= 1'b0;
            negRes  <= 1'b0;
            negRem  <= 1'b0;
            divZero <= 1'b0;
            doneReg <= 1'b0;
            dbzReg  <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            dbzReg  <= 1'b0;
            case (state)
                IDLE: begin
                    if (acceptStart) begin
`ifdef MULDIV_FAST_MUL_EN
                        if (fastMul) begin
                            hiReg   <= fastProd[2*W-1:W];
                            loReg   <= fastProd[W-1:0];
                            doneReg <= 1'b1;
                        end
`endif
                        isDiv   <= i_Op[1];
                        negRes  <= signA ^ signB;
                        negRem  <= signA;
                        divZero <= (i_SrcB == '0);
                        opB     <= magB;
                        accHi   <= '0;
                        accLo   <= magA;
                        counter <= CW'(W - 1);
                    end else if (!i_Kill && !i_Start) begin
                        if (i_MTHI) hiReg <= i_SrcA;
                        if (i_MTLO) loReg <= i_SrcA;
                    end
                end
                RUN: begin
                    if (i_Kill) begin
                        counter <= '0;
                    end else begin
                        if (isDiv) begin
                            accHi <= divFits ? divDiff[W-1:0] : divShift[W-1:0];
                            accLo <= {accLo[W-2:0], divFits};
                        end else begin
                            accHi <= mulSum[W:1];
                            accLo <= {mulSum[0], accLo[W-1:1]};
                        end
                        if (counter != '0) counter <= counter - CW'(1);
                    end
                end
                FIX: begin
                    if (!i_Kill) begin
                        hiReg   <= resHi;
                        loReg   <= resLo;
                        doneReg <= 1'b1;
                        dbzReg  <= isDiv & divZero;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
